// File: rtl/tetris_input_if.sv
// Request bus from the game core into tetris_input:
// hold and garbage-bar requests.
interface tetris_input_if;
    logic       hold_req;
    logic       bar_req;
    logic [9:0] bar_in;

    modport master (
        output hold_req,
        output bar_req,
        output bar_in
    );

    modport slave (
        input hold_req,
        input bar_req,
        input bar_in
    );
endinterface

// File: rtl/tetris_input.sv
// Tetris input front end: debounce, auto-repeat, gravity timer
// and a pending-command arbiter feeding the game core.
package tetris_pkg;
    typedef enum logic [3:0] {
        NONE   = 4'd0,
        INIT   = 4'd1,
        GEN    = 4'd2,
        WAIT   = 4'd3,
        LEFT   = 4'd4,
        RIGHT  = 4'd5,
        ROTATE = 4'd6,
        DOWN   = 4'd7,
        DROP   = 4'd8,
        HOLD   = 4'd9,
        BAR    = 4'd10,
        END    = 4'd11
    } state_type;
endpackage

module tetris_input
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DELAY = 30_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int GRAVITY_CYC  = 50_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    btn,
    tetris_input_if.slave req,
    input  state_type     game_state,
    input  logic [15:0]   score,
    output state_type     ctrl,
    output logic [9:0]    bar_mask,
    output logic [2:0]    level
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE)
                        ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);
    localparam int GW = $clog2(GRAVITY_CYC + 1);

    localparam int F_GRAV  = 0;
    localparam int F_DOWN  = 1;
    localparam int F_RIGHT = 2;
    localparam int F_LEFT  = 3;
    localparam int F_ROT   = 4;
    localparam int F_DROP  = 5;
    localparam int F_HOLD  = 6;
    localparam int F_BAR   = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } fsm_t;

    fsm_t state, state_n;

    logic [4:0]    sync1, sync2;
    logic [4:0]    stable, stable_d;
    logic [DW-1:0] db_cnt [5];
    logic [4:0]    press;

    logic [RW-1:0] rp_cnt [3];
    logic [2:0]    rp_phase;
    logic [2:0]    rp_held;
    logic [2:0]    rp_hit;
    logic [4:0]    ev;

    logic [7:0]    flags, flags_n, set, clr;
    logic [9:0]    bar_row;
    logic          bar_ok;
    logic          frozen, running;
    logic [GW-1:0] grav_cnt, grav_thr;
    logic          grav_tick;
    logic [2:0]    level_n;
    state_type     cmd;
    logic          unused_ok;

    assign unused_ok = ^score[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    db_cnt[i] <= '0;
                    stable[i] <= ~stable[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press   = stable & ~stable_d;
    assign rp_held = {stable[3], stable[1], stable[0]};

    // rp_cnt tracks cycles since the press or the last repeat
    always_comb begin
        rp_hit = '0;
        for (int j = 0; j < 3; j++) begin
            if (rp_phase[j])
                rp_hit[j] = rp_held[j]
                          && rp_cnt[j] == RW'(REPEAT_RATE);
            else
                rp_hit[j] = rp_held[j]
                          && rp_cnt[j] == RW'(REPEAT_DELAY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rp_phase <= '0;
            for (int j = 0; j < 3; j++) rp_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (!rp_held[j]) begin
                    rp_cnt[j]   <= '0;
                    rp_phase[j] <= 1'b0;
                end else if (rp_hit[j]) begin
                    rp_cnt[j]   <= RW'(1);
                    rp_phase[j] <= 1'b1;
                end else begin
                    rp_cnt[j] <= rp_cnt[j] + 1'b1;
                end
            end
        end
    end

    assign ev = press
              | {1'b0, rp_hit[2], 1'b0, rp_hit[1], rp_hit[0]};

    assign frozen  = game_state == INIT || game_state == END;
    assign running = !frozen && game_state != GEN;

    assign grav_thr  = GW'((GRAVITY_CYC >> level) - 1);
    assign grav_tick = running && grav_cnt >= grav_thr;

    assign bar_ok = req.bar_req && req.bar_in != '0
                  && !flags[F_BAR];

    always_comb begin
        set          = '0;
        set[F_BAR]   = bar_ok;
        set[F_HOLD]  = req.hold_req;
        set[F_DROP]  = ev[4];
        set[F_ROT]   = ev[2];
        set[F_LEFT]  = ev[0];
        set[F_RIGHT] = ev[1];
        set[F_DOWN]  = ev[3];
        set[F_GRAV]  = grav_tick;
    end

    always_comb begin
        if (|score[15:8])
            level_n = 3'd4;
        else if (score[7:4] > 4'd4)
            level_n = 3'd4;
        else
            level_n = score[6:4];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        cmd     = NONE;
        clr     = '0;
        unique case (state)
            IDLE: begin
                if (frozen) begin
                    // any press starts or restarts the game
                    if (|press) begin
                        state_n = ISSUE;
                        cmd     = DOWN;
                    end
                end else if (game_state == WAIT && |flags) begin
                    state_n = ISSUE;
                    priority case (1'b1)
                        flags[F_BAR]: begin
                            cmd        = BAR;
                            clr[F_BAR] = 1'b1;
                        end
                        flags[F_HOLD]: begin
                            cmd         = HOLD;
                            clr[F_HOLD] = 1'b1;
                        end
                        flags[F_DROP]: begin
                            cmd         = DROP;
                            clr[F_DROP] = 1'b1;
                        end
                        flags[F_ROT]: begin
                            cmd        = ROTATE;
                            clr[F_ROT] = 1'b1;
                        end
                        flags[F_LEFT]: begin
                            cmd         = LEFT;
                            clr[F_LEFT] = 1'b1;
                        end
                        flags[F_RIGHT]: begin
                            cmd          = RIGHT;
                            clr[F_RIGHT] = 1'b1;
                        end
                        default: begin
                            cmd         = DOWN;
                            clr[F_DOWN] = 1'b1;
                            clr[F_GRAV] = 1'b1;
                        end
                    endcase
                end
            end
            ISSUE: state_n = BUSY;
            BUSY: begin
                if (game_state == WAIT) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // set wins over clr so a same-cycle event is kept
    assign flags_n = frozen ? '0 : ((flags & ~clr) | set);

    always_ff @(posedge clk) begin
        if (reset) begin
            flags    <= '0;
            bar_row  <= '0;
            grav_cnt <= '0;
            level    <= '0;
            ctrl     <= NONE;
            bar_mask <= '0;
        end else begin
            flags <= flags_n;
            level <= level_n;
            ctrl  <= cmd;
            if (bar_ok) bar_row <= req.bar_in;
            if (cmd == BAR) bar_mask <= bar_row;
            else            bar_mask <= '0;
            if (!running || grav_tick) grav_cnt <= '0;
            else grav_cnt <= grav_cnt + 1'b1;
        end
    end

endmodule

// File: doc/tetris_input.md
TETRIS_INPUT -- requirements
Module: tetris_input

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1_000_000; consecutive cycles a raw button must differ from its debounced value before that value flips.
REQ-002 Parameter REPEAT_DELAY, default 30_000_000; hold cycles before auto-repeat begins.
REQ-003 Parameter REPEAT_RATE, default 5_000_000; cycles between auto-repeat events.
REQ-004 Parameter GRAVITY_CYC, default 50_000_000; gravity period at level 0.
REQ-005 Port: clk  in  1  sole clock; all logic on posedge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: btn  in  5  raw asynchronous pushbuttons; [0]=LEFT, [1]=RIGHT, [2]=ROTATE, [3]=DOWN, [4]=DROP.
REQ-008 Port: hold_req  in  1  single-cycle hold request.
REQ-009 Port: bar_req  in  1  single-cycle garbage-bar request.
REQ-010 Port: bar_in  in  10  garbage row, sampled on bar_req.
REQ-011 Port: game_state  in  state_type  current game-core state.
REQ-012 Port: score  in  16  4-digit BCD line count from the game core.
REQ-013 Port: ctrl  out  state_type  registered command to the game core; NONE when idle.
REQ-014 Port: bar_mask  out  10  registered bar row; valid only while ctrl==BAR.
REQ-015 Port: level  out  3  registered gravity level, 0..4.

Function
REQ-016 Each btn bit SHALL pass a 2-flop synchronizer, then a debouncer that flips the stable value after DEBOUNCE_CYC consecutive disagreeing cycles; any agreeing cycle clears the count.
REQ-017 A press event SHALL fire on each 0->1 transition of a stable button.
REQ-018 LEFT, RIGHT and DOWN SHALL auto-repeat: extra events at REPEAT_DELAY cycles after the press, then every REPEAT_RATE cycles while held; ROTATE and DROP never repeat.
REQ-019 Eight pending flags: BAR, HOLD, DROP, ROTATE, LEFT, RIGHT, DOWN, GRAV; an event sets its flag, and repeated events before issue coalesce.
REQ-020 bar_req with nonzero bar_in and BAR flag clear SHALL latch bar_in and set BAR; bar_req while BAR is pending, or with bar_in==0, is ignored.
REQ-021 Issue FSM states IDLE, ISSUE, BUSY; in every state other than ISSUE, ctrl==NONE and bar_mask==0.
REQ-022 IDLE->ISSUE when game_state==WAIT and any flag is set; the highest-priority flag is selected, priority BAR>HOLD>DROP>ROTATE>LEFT>RIGHT>DOWN>GRAV.
REQ-023 In ISSUE, for exactly one cycle, ctrl SHALL equal the selected command; GRAV maps to DOWN.
REQ-024 The selected flag clears on entering ISSUE; selecting DOWN or GRAV clears both flags.
REQ-025 In ISSUE, bar_mask SHALL equal the latched row when ctrl==BAR.
REQ-026 ISSUE->BUSY unconditionally; BUSY stays at least one cycle, then BUSY->IDLE on the first cycle game_state==WAIT.
REQ-027 While game_state is INIT or END: all flags SHALL be forced clear each cycle and the gravity counter held at 0.
REQ-028 While game_state is INIT or END, any button press event SHALL issue DOWN through IDLE->ISSUE->BUSY as a start/restart command.
REQ-029 Gravity counter SHALL increment every cycle in any other game_state.
REQ-030 When the gravity counter reaches (GRAVITY_CYC>>level)-1, the block SHALL set GRAV and wrap the counter to 0.
REQ-031 The gravity counter SHALL be cleared to 0 whenever game_state==GEN.
REQ-032 level SHALL be 4 if score[15:8]!=0; otherwise min(score[7:4],4); updated every cycle.
REQ-033 A flag set in the same cycle it is cleared by issue SHALL remain set, so the event is not lost.

Reset
REQ-034 On reset: ctrl=NONE, bar_mask=0, level=0, FSM=IDLE, all flags, counters, debounced values and bar latch =0.
REQ-035 Reset asserted mid-ISSUE or mid-BUSY SHALL return the block to IDLE on the next edge with no further command emitted.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=5, GRAVITY_CYC=64)
REQ-036 game_state=WAIT; btn[0] held 3 cycles then released -> no command; held 40 cycles -> LEFT press, then LEFT at +20 and +25, +30, +35 (each a one-cycle pulse with BUSY handshake).
REQ-037 game_state=WAIT; bar_req with bar_in=0x3F0 together with a DROP press -> ctrl=BAR with bar_mask=0x3F0, then DROP after game_state returns to WAIT.
REQ-038 game_state=WAIT, score=0x0000 -> DOWN every 64 cycles; score=0x0020 -> every 16 cycles; score=0x0100 -> level=4, every 4 cycles.
REQ-039 game_state=END with flags pending; press ROTATE -> flags cleared, single DOWN pulse, no ROTATE emitted.
REQ-040 game_state held at DOWN, never returning to WAIT, with a LEFT press -> ctrl stays NONE; release game_state to WAIT -> LEFT issued one cycle later.
REQ-041 reset during ISSUE of HOLD -> ctrl=NONE next cycle, HOLD never reissued.
